// File: rtl/psum_accum_engine.sv
// Purpose  : partial-sum accumulator; read-modify-write of one packed psum word per beat, with RAW forwarding.
// Latency  : beat at t -> mem_rden at t, mem_oval at t+MEM_DELAY, registered write at t+MEM_DELAY+1.
// Backpress: none; accepts one beat per cycle, never stalls.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   psum_dat/psum_vld/psum_end  PE-array beat (lane k at [k*PSUM_WIDTH +: PSUM_WIDTH]), end-of-pass
//   i_conf_*                   beat period, base step, first-pass overwrite, saturate/wrap select
//   mem_radd/mem_rden          read request (combinational from the current beat)
//   mem_odat/mem_oval          read return, exactly MEM_DELAY cycles after mem_rden
//   mem_wadd/mem_wren/mem_idat registered write port
//   busy, o_ovf, o_err         beat in flight, sticky lane overflow, sticky read-return slot error
module psum_accum_engine #(
    parameter int NUM_KERNEL = 4,
    parameter int PSUM_WIDTH = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int MEM_DELAY  = 1,
    parameter int REG_WIDTH  = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_KERNEL*PSUM_WIDTH-1:0] psum_dat,
    input  logic                             psum_vld,
    input  logic                             psum_end,
    input  logic [REG_WIDTH-1:0]             i_conf_weightinterval,
    input  logic [REG_WIDTH-1:0]             i_conf_inputrstcnt,
    input  logic                             i_conf_first,
    input  logic                             i_conf_sat,
    output logic [ADDR_WIDTH-1:0]            mem_radd,
    output logic                             mem_rden,
    input  logic [NUM_KERNEL*PSUM_WIDTH-1:0] mem_odat,
    input  logic                             mem_oval,
    output logic [ADDR_WIDTH-1:0]            mem_wadd,
    output logic                             mem_wren,
    output logic [NUM_KERNEL*PSUM_WIDTH-1:0] mem_idat,
    output logic                             busy,
    output logic                             o_ovf,
    output logic                             o_err
);
    localparam int DW   = NUM_KERNEL * PSUM_WIDTH;
    localparam int PW   = PSUM_WIDTH;
    localparam int HEAD = MEM_DELAY - 1;

    // Address generation
    logic [REG_WIDTH-1:0]  cnt;
    logic [ADDR_WIDTH-1:0] base;
    logic [ADDR_WIDTH-1:0] base_nxt;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  wrap;
    logic                  unused_cfg;

    assign wrap     = psum_vld && (cnt == i_conf_weightinterval);
    assign base_nxt = wrap ? base + i_conf_inputrstcnt[ADDR_WIDTH-1:0] + ADDR_WIDTH'(1) : base;
    // Base arithmetic is modulo the address space, so the upper config bits never matter.
    assign unused_cfg = ^i_conf_inputrstcnt[REG_WIDTH-1:ADDR_WIDTH];

    assign mem_rden = psum_vld & ~rst;
    assign mem_radd = rd_addr;

    // Tag pipe: stage 0 is loaded at issue, stage HEAD lines up with the read return.
    logic                  tg_vld   [MEM_DELAY];
    logic [ADDR_WIDTH-1:0] tg_addr  [MEM_DELAY];
    logic [DW-1:0]         tg_psum  [MEM_DELAY];
    logic                  tg_first [MEM_DELAY];
    logic                  tg_sat   [MEM_DELAY];

    // Write history: entry 0 is the write on the port this cycle, entry MEM_DELAY is the
    // write issued in the same cycle as the read now returning (not seen by the memory).
    logic                  wh_vld  [MEM_DELAY+1];
    logic [ADDR_WIDTH-1:0] wh_addr [MEM_DELAY+1];
    logic [DW-1:0]         wh_dat  [MEM_DELAY+1];

    assign mem_wren = wh_vld[0];
    assign mem_wadd = wh_addr[0];
    assign mem_idat = wh_dat[0];

    logic tag_any;
    always_comb begin
        tag_any = 1'b0;
        for (int i = 0; i < MEM_DELAY; i++) tag_any = tag_any | tg_vld[i];
    end
    assign busy = ~rst & (psum_vld | tag_any | wh_vld[0]);

    // Return stage: pick the old word, add lanes in PW+1 bits, then clamp or truncate.
    logic [DW-1:0] old_word;
    logic [DW-1:0] res_word;
    logic          ovf_any;

    always_comb begin
        logic [PW:0] s;
        s        = '0;
        old_word = mem_odat;
        // Scan oldest to youngest so the youngest matching write wins.
        for (int i = MEM_DELAY; i >= 0; i--) begin
            if (wh_vld[i] && (wh_addr[i] == tg_addr[HEAD])) old_word = wh_dat[i];
        end
        res_word = '0;
        ovf_any  = 1'b0;
        for (int k = 0; k < NUM_KERNEL; k++) begin
            s = (tg_first[HEAD] ? {(PW+1){1'b0}} : {old_word[k*PW+PW-1], old_word[k*PW +: PW]})
              + {tg_psum[HEAD][k*PW+PW-1], tg_psum[HEAD][k*PW +: PW]};
            if (s[PW] != s[PW-1]) begin
                ovf_any = 1'b1;
                // Sign of the exact sum selects the rail: negative -> min, positive -> max.
                res_word[k*PW +: PW] = tg_sat[HEAD] ? {s[PW], {(PW-1){~s[PW]}}} : s[PW-1:0];
            end else begin
                res_word[k*PW +: PW] = s[PW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            base    <= '0;
            rd_addr <= '0;
            for (int i = 0; i < MEM_DELAY; i++) begin
                tg_vld[i]   <= 1'b0;
                tg_addr[i]  <= '0;
                tg_psum[i]  <= '0;
                tg_first[i] <= 1'b0;
                tg_sat[i]   <= 1'b0;
            end
            for (int i = 0; i <= MEM_DELAY; i++) begin
                wh_vld[i]  <= 1'b0;
                wh_addr[i] <= '0;
                wh_dat[i]  <= '0;
            end
            o_ovf <= 1'b0;
            o_err <= 1'b0;
        end else begin
            if (psum_vld) cnt <= wrap ? '0 : cnt + REG_WIDTH'(1);
            base <= base_nxt;
            if (psum_end)      rd_addr <= base_nxt;
            else if (psum_vld) rd_addr <= rd_addr + ADDR_WIDTH'(1);

            tg_vld[0]   <= psum_vld;
            tg_addr[0]  <= rd_addr;
            tg_psum[0]  <= psum_dat;
            tg_first[0] <= i_conf_first;
            tg_sat[0]   <= i_conf_sat;
            for (int i = 1; i < MEM_DELAY; i++) begin
                tg_vld[i]   <= tg_vld[i-1];
                tg_addr[i]  <= tg_addr[i-1];
                tg_psum[i]  <= tg_psum[i-1];
                tg_first[i] <= tg_first[i-1];
                tg_sat[i]   <= tg_sat[i-1];
            end

            wh_vld[0]  <= tg_vld[HEAD];
            wh_addr[0] <= tg_addr[HEAD];
            wh_dat[0]  <= res_word;
            for (int i = 1; i <= MEM_DELAY; i++) begin
                wh_vld[i]  <= wh_vld[i-1];
                wh_addr[i] <= wh_addr[i-1];
                wh_dat[i]  <= wh_dat[i-1];
            end

            if (tg_vld[HEAD] && ovf_any) o_ovf <= 1'b1;
            // Data always follows the tag; a return in the wrong slot is only flagged.
            if (mem_oval != tg_vld[HEAD]) o_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_psum_accum_engine.sv
module tb_psum_accum_engine;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] psum_dat;
    logic        psum_vld, psum_end, conf_first, conf_sat;
    logic [31:0] conf_wi, conf_irc;
    logic [1:0]  drop;
    logic        pre_we;
    logic [15:0] pre_addr;
    logic [31:0] pre_dat;

    wire [1:0][15:0] mem_radd, mem_wadd;
    wire [1:0][31:0] mem_odat, mem_idat;
    wire [1:0]       mem_rden, mem_oval, mem_wren, busy, o_ovf, o_err;

    int n_chk  = 0;
    int n_fail = 0;

    // Instance 0 uses MEM_DELAY=1, instance 1 uses MEM_DELAY=2; each has its own memory.
    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int D = g + 1;
        logic [31:0] mem [65536];
        logic [31:0] pd [D];
        logic        pv [D];

        always @(posedge clk) begin
            pv[0] <= mem_rden[g] & ~drop[g];
            pd[0] <= mem[mem_radd[g]];
            for (int i = 1; i < D; i++) begin
                pv[i] <= pv[i-1];
                pd[i] <= pd[i-1];
            end
            if (mem_wren[g]) mem[mem_wadd[g]] <= mem_idat[g];
            if (pre_we)      mem[pre_addr]    <= pre_dat;
        end
        assign mem_oval[g] = pv[D-1];
        assign mem_odat[g] = pd[D-1];

        psum_accum_engine #(
            .NUM_KERNEL(4), .PSUM_WIDTH(8), .ADDR_WIDTH(16), .MEM_DELAY(D), .REG_WIDTH(32)
        ) u_dut (
            .clk(clk), .rst(rst),
            .psum_dat(psum_dat), .psum_vld(psum_vld), .psum_end(psum_end),
            .i_conf_weightinterval(conf_wi), .i_conf_inputrstcnt(conf_irc),
            .i_conf_first(conf_first), .i_conf_sat(conf_sat),
            .mem_radd(mem_radd[g]), .mem_rden(mem_rden[g]),
            .mem_odat(mem_odat[g]), .mem_oval(mem_oval[g]),
            .mem_wadd(mem_wadd[g]), .mem_wren(mem_wren[g]), .mem_idat(mem_idat[g]),
            .busy(busy[g]), .o_ovf(o_ovf[g]), .o_err(o_err[g])
        );
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one cycle of beat inputs just after the edge, then settle for sampling.
    task automatic drive(input logic v, input logic e, input logic [31:0] d, input logic f, input logic s);
        @(posedge clk); #1;
        psum_vld = v; psum_end = e; psum_dat = d; conf_first = f; conf_sat = s;
        #1;
    endtask

    task automatic do_reset;
        @(posedge clk); #1;
        rst = 1'b1; psum_vld = 1'b0; psum_end = 1'b0; drop = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic preload(input logic [15:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        pre_we = 1'b1; pre_addr = a; pre_dat = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    typedef struct {
        logic        vld;
        logic [31:0] dat;
        logic        first;
        logic        sat;
        logic        e_rden;
        logic [15:0] e_radd;
        logic        e_wren;
        logic [15:0] e_wadd;
        logic [31:0] e_idat;
        logic        e_busy;
        logic        e_ovf;
    } vec_t;

    vec_t        tv [7];
    logic [15:0] exp_b [7];

    initial begin
        // Lane 0 is the least significant byte of each word.
        tv[0] = '{1'b1, 32'h281E140A, 1'b0, 1'b0, 1'b1, 16'd0, 1'b0, 16'd0, 32'h0,        1'b1, 1'b0};
        tv[1] = '{1'b1, 32'h0700FD05, 1'b1, 1'b0, 1'b1, 16'd1, 1'b0, 16'd0, 32'h0,        1'b1, 1'b0};
        tv[2] = '{1'b1, 32'h0000CE14, 1'b0, 1'b1, 1'b1, 16'd2, 1'b1, 16'd0, 32'h2C21160B, 1'b1, 1'b0};
        tv[3] = '{1'b1, 32'h0000CE14, 1'b0, 1'b0, 1'b1, 16'd3, 1'b1, 16'd1, 32'h0700FD05, 1'b1, 1'b0};
        tv[4] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 16'd2, 32'h0000807F, 1'b1, 1'b1};
        tv[5] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 16'd3, 32'h00006A8C, 1'b1, 1'b1};
        tv[6] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 16'd0, 32'h0,        1'b0, 1'b1};
        exp_b = '{16'd0, 16'd1, 16'd2, 16'd10, 16'd11, 16'd12, 16'd20};

        rst = 1'b1; psum_vld = 1'b0; psum_end = 1'b0; psum_dat = '0;
        conf_first = 1'b0; conf_sat = 1'b0; conf_wi = 32'd1000; conf_irc = 32'd0;
        drop = 2'b00; pre_we = 1'b0; pre_addr = '0; pre_dat = '0;

        // Reset state, and mem_rden gated while in reset
        repeat (3) @(posedge clk);
        #1;
        chk("rst wren",  mem_wren[0], 1'b0);
        chk("rst wadd",  mem_wadd[0], 16'd0);
        chk("rst idat",  mem_idat[0], 32'd0);
        chk("rst ovf",   o_ovf[0],    1'b0);
        chk("rst err",   o_err[0],    1'b0);
        psum_vld = 1'b1;
        #1;
        chk("rst rden0", mem_rden[0], 1'b0);
        chk("rst rden1", mem_rden[1], 1'b0);
        chk("rst busy",  busy[0],     1'b0);
        psum_vld = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        // Accumulate / first-pass / saturate / wrap table on the MEM_DELAY=1 instance
        preload(16'd0, 32'h04030201);
        preload(16'd1, 32'h55555555);
        preload(16'd2, 32'h00009C78);
        preload(16'd3, 32'h00009C78);
        for (int r = 0; r < 7; r++) begin
            drive(tv[r].vld, 1'b0, tv[r].dat, tv[r].first, tv[r].sat);
            chk($sformatf("row%0d rden", r), mem_rden[0], tv[r].e_rden);
            if (tv[r].e_rden) chk($sformatf("row%0d radd", r), mem_radd[0], tv[r].e_radd);
            chk($sformatf("row%0d wren", r), mem_wren[0], tv[r].e_wren);
            if (tv[r].e_wren) begin
                chk($sformatf("row%0d wadd", r), mem_wadd[0], tv[r].e_wadd);
                chk($sformatf("row%0d idat", r), mem_idat[0], tv[r].e_idat);
            end
            chk($sformatf("row%0d busy", r), busy[0], tv[r].e_busy);
            chk($sformatf("row%0d ovf", r),  o_ovf[0], tv[r].e_ovf);
        end

        // Base stepping: period 3 beats, base step 10, psum_end on beats 3 and 6
        conf_wi = 32'd2; conf_irc = 32'd9;
        do_reset;
        chk("ovf cleared", o_ovf[0], 1'b0);
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, (i == 2) || (i == 5), 32'h01010101, 1'b1, 1'b0);
            chk($sformatf("base radd%0d", i), mem_radd[0], exp_b[i]);
        end

        // weightinterval = 0: base advances on every beat
        conf_wi = 32'd0; conf_irc = 32'd3;
        do_reset;
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0); chk("wi0 radd a", mem_radd[0], 16'd0);
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0); chk("wi0 radd b", mem_radd[0], 16'd1);
        drive(1'b0, 1'b1, 32'h0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0); chk("wi0 radd c", mem_radd[0], 16'd8);

        // Address wrap at the top of the address space
        conf_irc = 32'h0000FFFE;
        do_reset;
        drive(1'b1, 1'b1, 32'hA5A5A5A5, 1'b1, 1'b0); chk("wrap radd a", mem_radd[0], 16'h0000);
        drive(1'b1, 1'b0, 32'hA5A5A5A5, 1'b1, 1'b0); chk("wrap radd b", mem_radd[0], 16'hFFFF);
        drive(1'b1, 1'b0, 32'hA5A5A5A5, 1'b1, 1'b0); chk("wrap radd c", mem_radd[0], 16'h0000);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("wrap wren", mem_wren[0], 1'b1);
        chk("wrap wadd", mem_wadd[0], 16'hFFFF);
        chk("wrap idat", mem_idat[0], 32'hA5A5A5A5);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("wrap err", o_err[0], 1'b0);

        // Forwarding hazard on the MEM_DELAY=2 instance: two passes over addr 0,1
        conf_wi = 32'd1000; conf_irc = 32'd0;
        do_reset;
        preload(16'd0, 32'h0);
        preload(16'd1, 32'h0);
        drive(1'b1, 1'b0, 32'h01010101, 1'b0, 1'b0); chk("fwd radd0", mem_radd[1], 16'd0);
        drive(1'b1, 1'b1, 32'h01010101, 1'b0, 1'b0); chk("fwd radd1", mem_radd[1], 16'd1);
        drive(1'b1, 1'b0, 32'h01010101, 1'b0, 1'b0); chk("fwd radd2", mem_radd[1], 16'd0);
        drive(1'b1, 1'b0, 32'h01010101, 1'b0, 1'b0); chk("fwd radd3", mem_radd[1], 16'd1);
        chk("fwd w0 wren", mem_wren[1], 1'b1);
        chk("fwd w0 wadd", mem_wadd[1], 16'd0);
        chk("fwd w0 idat", mem_idat[1], 32'h01010101);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("fwd w1 wadd", mem_wadd[1], 16'd1);
        chk("fwd w1 idat", mem_idat[1], 32'h01010101);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("fwd w2 wren", mem_wren[1], 1'b1);
        chk("fwd w2 wadd", mem_wadd[1], 16'd0);
        chk("fwd w2 idat", mem_idat[1], 32'h02020202);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("fwd w3 wadd", mem_wadd[1], 16'd1);
        chk("fwd w3 idat", mem_idat[1], 32'h02020202);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("fwd done wren", mem_wren[1], 1'b0);
        chk("fwd done busy", busy[1], 1'b0);
        chk("fwd err", o_err[1], 1'b0);

        // Reset one cycle after a beat: the in-flight beat never writes
        drive(1'b1, 1'b0, 32'h11111111, 1'b1, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin rst = 1'b1; psum_vld = 1'b1; end
            if (i == 4) begin rst = 1'b0; psum_vld = 1'b0; end
            #1;
            if (i == 1) begin
                chk("midrst rden0", mem_rden[0], 1'b0);
                chk("midrst rden1", mem_rden[1], 1'b0);
            end
            chk($sformatf("midrst wren0 c%0d", i), mem_wren[0], 1'b0);
            chk($sformatf("midrst wren1 c%0d", i), mem_wren[1], 1'b0);
        end

        // Missing read return on one slot: sticky o_err until reset
        chk("err pre0", o_err[0], 1'b0);
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        drop[0] = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        drop[0] = 1'b0;
        chk("err slot", o_err[0], 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("err set", o_err[0], 1'b1);
        chk("err other inst", o_err[1], 1'b0);
        repeat (3) drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("err sticky", o_err[0], 1'b1);
        do_reset;
        chk("err cleared", o_err[0], 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/psum_accum_engine.md
# psum_accum_engine

Parametrised partial-sum accumulator for the convolution datapath. It takes NUM_KERNEL signed partial sums per beat from the PE array and issues a read-modify-write to one packed accumulator word in the psum memory. It supports a configurable memory read latency, first-pass overwrite, and saturating or wrapping lane arithmetic. Read-after-write hazards are resolved by forwarding, so back-to-back passes over the same addresses accumulate correctly.

## Interface
- NUM_KERNEL, 4, lanes per memory word
- PSUM_WIDTH, 8, signed lane width (bits)
- ADDR_WIDTH, 16, memory address width
- MEM_DELAY, 1, memory read latency in cycles, legal 1..4
- REG_WIDTH, 32, config register width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- psum_dat  in  NUM_KERNEL*PSUM_WIDTH  lane k at bits [k*PSUM_WIDTH +: PSUM_WIDTH]
- psum_vld  in  1  beat valid; no backpressure, one beat per cycle max
- psum_end  in  1  end of pass; reload read address from base
- i_conf_weightinterval  in  REG_WIDTH  beats per base period minus 1
- i_conf_inputrstcnt  in  REG_WIDTH  base advance minus 1
- i_conf_first  in  1  first channel group: write psum, ignore memory contents
- i_conf_sat  in  1  1 = saturate, 0 = wrap
- mem_radd  out  ADDR_WIDTH  read address
- mem_rden  out  1  read enable
- mem_odat  in  NUM_KERNEL*PSUM_WIDTH  read data
- mem_oval  in  1  read data valid, exactly MEM_DELAY cycles after mem_rden
- mem_wadd  out  ADDR_WIDTH  write address
- mem_wren  out  1  write enable
- mem_idat  out  NUM_KERNEL*PSUM_WIDTH  write data
- busy  out  1  any beat in flight
- o_ovf  out  1  sticky: a lane saturated or wrapped
- o_err  out  1  sticky: mem_oval mismatch with the expected slot

## Operation
- Beat counter cnt: on a psum_vld cycle, if cnt == weightinterval then cnt <= 0, otherwise cnt <= cnt+1.
- base: on a psum_vld cycle where cnt == weightinterval, base <= base + inputrstcnt + 1 (mod 2^ADDR_WIDTH). Base advances once per wrap.
- rd_addr: a beat uses the current rd_addr.
  - If psum_end, next rd_addr = next base value. psum_end has priority, including when it coincides with psum_vld.
  - Otherwise, on psum_vld, rd_addr + 1 (wraps mod 2^ADDR_WIDTH).
- Issue: mem_rden = psum_vld and mem_radd = rd_addr (combinational). In first mode, mem_rden is still asserted.
- Tag pipe of depth MEM_DELAY carries {vld, addr, psum, first, sat}. Config is sampled at issue.
- Return stage: when the tag at the pipe head is valid, per lane sum = (first ? 0 : old) + psum.
  - old is the youngest forwarded entry whose address matches, otherwise mem_odat.
- Forwarding: a history of the last MEM_DELAY+1 writes {addr, data, vld} is kept. A write issued in cycle w is visible to reads issued after w; any earlier match is taken from the history.
- Arithmetic: add in PSUM_WIDTH+1 bits.
  - sat = 1: clamp to [-2^(PSUM_WIDTH-1), 2^(PSUM_WIDTH-1)-1].
  - sat = 0: truncate.
  - o_ovf is set if any lane result differs from its exact sum.
- o_err is set when mem_oval ≠ expected tag valid. Data is still processed per the tag, never per mem_oval.

## Timing
- Beat accepted at cycle t → mem_rden at t, mem_oval expected at t+MEM_DELAY, mem_wren and mem_idat/mem_wadd registered at t+MEM_DELAY+1.
- Throughput is 1 beat per cycle with no stalls.
- busy is asserted from t through t+MEM_DELAY+1 for any in-flight beat.
- Reset values: cnt = 0, base = 0, rd_addr = 0; tag pipe and history invalid; mem_wren = 0, mem_wadd = 0, mem_idat = 0, busy = 0, o_ovf = 0, o_err = 0. mem_rden follows psum_vld, gated low while rst.
- Reset mid-operation: all in-flight beats are dropped and no write is issued after the rst cycle.
- weightinterval = 0: base advances on every beat.
- Address wrap at 2^ADDR_WIDTH − 1 → 0 is required, with no error.

## Test plan
- Basic accumulation: MEM_DELAY=1, memory word 0 = {1,2,3,4}, beat {10,20,30,40} at addr 0, first=0, sat=0 → write {11,22,33,44} to addr 0 at t+2.
- First-pass overwrite: first=1, memory holds garbage 0x55 per lane, beat {5,−3,0,7} → write {5,−3,0,7}. Memory contents are ignored.
- Saturation:
  - sat=1: old = 120, psum = 20 → 127, and o_ovf=1.
  - sat=0: same operands → −116.
  - old = −100, psum = −50 with sat=1 → −128.
- Forwarding hazard: MEM_DELAY=2, beats at addr 0 and 1, psum_end, then immediate beats at addr 0 and 1 again, each lane +1 from 0 → final writes to addr 0 and 1 equal 2. The second pass must forward the first pass's pending writes.
- Base stepping: weightinterval=2, inputrstcnt=9, 6 beats with psum_end after the 3rd and 6th → read addresses 0,1,2,10,11,12, base = 20.
- Reset and error: assert rst at t+1 after a beat at t → no mem_wren follows. Separately, drop mem_oval for one expected slot → o_err = 1 and stays set until rst.
